// File: rtl/multi_cycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core.
// Define MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN to add the mem_ready handshake.
`timescale 1ns/1ps
module multi_cycle_main_fsm #(
  parameter int CNT_WIDTH    = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 zero,
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 error
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 mem_ok;

`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = TRAP_ILLEGAL ? S_ERROR : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires when control returns to FETCH; a held FETCH is not a return.
  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    error      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = mem_ok;
        pc_write   = mem_ok;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_ERROR:    error = 1'b1;
      default:    ;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_main_fsm.sv
// Directed bench for multi_cycle_main_fsm; a second instance (no trap, 3-bit
// counter) covers the non-trapping decode and counter wrap.
`timescale 1ns/1ps
module tb_multi_cycle_main_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
  logic       mem_ready;
`endif

  logic       pc_write, ir_write, adr_src, mem_write, reg_write, error;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic [3:0] state;
  logic [31:0] retired;

  logic       n_pc_write, n_ir_write, n_adr_src, n_mem_write, n_reg_write, n_error;
  logic [1:0] n_alu_src_a, n_alu_src_b, n_alu_op, n_result_src, n_imm_src;
  logic [3:0] n_state;
  logic [2:0] n_retired;

  int total = 0;
  int bad   = 0;

  multi_cycle_main_fsm #(.CNT_WIDTH(32), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .imm_src(imm_src), .state(state), .retired(retired), .error(error)
  );

  multi_cycle_main_fsm #(.CNT_WIDTH(3), .TRAP_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(n_pc_write), .ir_write(n_ir_write), .adr_src(n_adr_src),
    .mem_write(n_mem_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .result_src(n_result_src),
    .imm_src(n_imm_src), .state(n_state), .retired(n_retired), .error(n_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 7'b0010011;
    zero  = 1'b0;
    step();
    step();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    total++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000)
      begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {pc_write, ir_write, mem_write, reg_write}); end
    reset = 1'b0;
    #1;
    total++; if ({pc_write, ir_write} !== 2'b11) begin bad++; $display("FAIL fetch_enables got=%b exp=11", {pc_write, ir_write}); end
    total++; if ({adr_src, alu_src_a, alu_src_b, alu_op, result_src} !== 9'b0_00_10_00_10)
      begin bad++; $display("FAIL fetch_muxes got=%b exp=000100010", {adr_src, alu_src_a, alu_src_b, alu_op, result_src}); end
  endtask

  task automatic test_lw();
    int exp_st [6] = '{0, 1, 2, 3, 4, 0};
    op = 7'b0000011;
    for (int i = 0; i < 6; i++) begin
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      total++; if (reg_write !== (i == 4)) begin bad++; $display("FAIL lw_reg_write[%0d] got=%b exp=%b", i, reg_write, i == 4); end
      if (i == 3) begin
        total++; if ({adr_src, result_src} !== 3'b1_00) begin bad++; $display("FAIL lw_memread_mux got=%b exp=100", {adr_src, result_src}); end
      end
      if (i == 4) begin
        total++; if (result_src !== 2'b01) begin bad++; $display("FAIL lw_memwb_result got=%b exp=01", result_src); end
      end
      if (i < 5) step();
    end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL lw_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_sw();
    int exp_st [5] = '{0, 1, 2, 5, 0};
    int wr = 0;
    op = 7'b0100011;
    #1;
    total++; if (imm_src !== 2'b01) begin bad++; $display("FAIL sw_imm_src got=%b exp=01", imm_src); end
    for (int i = 0; i < 5; i++) begin
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      if (mem_write === 1'b1) wr++;
      if (i < 4) step();
    end
    total++; if (wr !== 1) begin bad++; $display("FAIL sw_mem_write_cycles got=%0d exp=1", wr); end
    total++; if (retired !== 32'd2) begin bad++; $display("FAIL sw_retired got=%0d exp=2", retired); end
  endtask

  task automatic test_beq(input logic z, input logic [31:0] exp_ret);
    int exp_st [4] = '{0, 1, 9, 0};
    op   = 7'b1100011;
    zero = z;
    #1;
    total++; if (imm_src !== 2'b10) begin bad++; $display("FAIL beq_imm_src got=%b exp=10", imm_src); end
    for (int i = 0; i < 4; i++) begin
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL beq_state[%0d] z=%b got=%0d exp=%0d", i, z, state, exp_st[i]); end
      if (i == 2) begin
        total++; if (pc_write !== z) begin bad++; $display("FAIL beq_pc_write z=%b got=%b exp=%b", z, pc_write, z); end
        total++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_00_01)
          begin bad++; $display("FAIL beq_alu_sel got=%b exp=100001", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (i < 3) step();
    end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL beq_retired got=%0d exp=%0d", retired, exp_ret); end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    int   exp_st [5] = '{0, 1, 10, 8, 0};
    logic exp_pc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 7'b1101111;
    #1;
    total++; if (imm_src !== 2'b11) begin bad++; $display("FAIL jal_imm_src got=%b exp=11", imm_src); end
    for (int i = 0; i < 5; i++) begin
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      total++; if (pc_write !== exp_pc[i]) begin bad++; $display("FAIL jal_pc_write[%0d] got=%b exp=%b", i, pc_write, exp_pc[i]); end
      total++; if (reg_write !== exp_rw[i]) begin bad++; $display("FAIL jal_reg_write[%0d] got=%b exp=%b", i, reg_write, exp_rw[i]); end
      if (i < 4) step();
    end
    total++; if (retired !== 32'd5) begin bad++; $display("FAIL jal_retired got=%0d exp=5", retired); end
  endtask

  task automatic test_rtype();
    int exp_st [5] = '{0, 1, 6, 8, 0};
    op = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL r_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      if (i == 2) begin
        total++; if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_00_10)
          begin bad++; $display("FAIL r_alu_sel got=%b exp=100010", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (i < 4) step();
    end
    total++; if (retired !== 32'd6) begin bad++; $display("FAIL r_retired got=%0d exp=6", retired); end
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL ill_decode got=%0d exp=1", state); end
    step();
    total++; if (n_state !== 4'd0) begin bad++; $display("FAIL nt_ill_state got=%0d exp=0", n_state); end
    total++; if (n_retired !== 3'd7) begin bad++; $display("FAIL nt_ill_retired got=%0d exp=7", n_retired); end
    op = 7'b1100011;
    for (int i = 0; i < 10; i++) begin
      total++; if (state !== 4'd15) begin bad++; $display("FAIL err_state[%0d] got=%0d exp=15", i, state); end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL err_flag[%0d] got=%b exp=1", i, error); end
      total++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000)
        begin bad++; $display("FAIL err_strobes[%0d] got=%b exp=0000", i, {pc_write, ir_write, mem_write, reg_write}); end
      if (i == 3) begin
        total++; if (n_state !== 4'd0) begin bad++; $display("FAIL nt_wrap_state got=%0d exp=0", n_state); end
        total++; if (n_retired !== 3'd0) begin bad++; $display("FAIL nt_wrap_retired got=%0d exp=0", n_retired); end
      end
      step();
    end
    total++; if (retired !== 32'd6) begin bad++; $display("FAIL err_retired got=%0d exp=6", retired); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL err_reset_state got=%0d exp=0", state); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL err_reset_retired got=%0d exp=0", retired); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_reset_flag got=%b exp=0", error); end
  endtask

  task automatic test_abort();
    int rw = 0;
    op = 7'b1100011;
    step(); step(); step();
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL abort_pre_retired got=%0d exp=1", retired); end
    op = 7'b0000011;
    step(); step(); step();
    total++; if (state !== 4'd3) begin bad++; $display("FAIL abort_memread got=%0d exp=3", state); end
    reset = 1'b1;
    #1;
    if (reg_write === 1'b1) rw++;
    step();
    reset = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", state); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL abort_retired got=%0d exp=0", retired); end
    if (reg_write === 1'b1) rw++;
    step();
    if (reg_write === 1'b1) rw++;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL abort_restart got=%0d exp=1", state); end
    total++; if (rw !== 0) begin bad++; $display("FAIL abort_reg_write got=%0d exp=0", rw); end
    op = 7'b0010011;
    step(); step(); step();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL itype_end got=%0d exp=0", state); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL itype_retired got=%0d exp=1", retired); end
  endtask

`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
  task automatic test_mem_wait();
    op = 7'b0110011;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({pc_write, ir_write} !== 2'b00) begin bad++; $display("FAIL wait_enables[%0d] got=%b exp=00", i, {pc_write, ir_write}); end
      total++; if (state !== 4'd0) begin bad++; $display("FAIL wait_state[%0d] got=%0d exp=0", i, state); end
      step();
    end
    mem_ready = 1'b1;
    #1;
    total++; if ({pc_write, ir_write} !== 2'b11) begin bad++; $display("FAIL wait_pulse got=%b exp=11", {pc_write, ir_write}); end
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL wait_decode got=%0d exp=1", state); end
    total++; if ({pc_write, ir_write} !== 2'b00) begin bad++; $display("FAIL wait_after got=%b exp=00", {pc_write, ir_write}); end
    step(); step(); step();
    total++; if (retired !== 32'd2) begin bad++; $display("FAIL wait_retired got=%0d exp=2", retired); end
  endtask
`endif

  initial begin
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_lw();
    test_sw();
    test_beq(1'b1, 32'd3);
    test_beq(1'b0, 32'd4);
    test_jal();
    test_rtype();
    test_illegal();
    test_abort();
`ifdef MULTI_CYCLE_MAIN_FSM_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
